// File: rtl/mdu_ctrl.sv
// Multiply/divide-unit control: sequences a multi-cycle external multiplier and owns HI/LO.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_MADDU = 3'b110;

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mul_a_q, mul_b_q, hi_q, lo_q;
  logic [63:0] prod_q;
  logic        neg_q, acc_q, busy_q, done_q;

  logic        is_mul_d, is_signed_d, is_acc_d;
  logic [31:0] mag_a_d, mag_b_d;
  logic [63:0] res_d, wr_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_mul_d    = 1'b0;
    is_signed_d = 1'b0;
    is_acc_d    = 1'b0;
    unique case (op)
      OP_MULT:  begin is_mul_d = 1'b1; is_signed_d = 1'b1; end
      OP_MULTU: is_mul_d = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul_d = 1'b1; is_signed_d = 1'b1; is_acc_d = 1'b1; end
      OP_MADDU: begin is_mul_d = 1'b1; is_acc_d = 1'b1; end
`else
      OP_MADD, OP_MADDU: ;
`endif
      default: ;
    endcase
  end

  // Two's-complement negation leaves 0x80000000 unchanged, which is its correct magnitude.
  assign mag_a_d = (is_signed_d && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
  assign mag_b_d = (is_signed_d && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

  assign res_d = neg_q ? (~prod_q + 64'd1) : prod_q;
  assign wr_d  = acc_q ? ({hi_q, lo_q} + res_d) : res_d;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      prod_q  <= 64'd0;
      neg_q   <= 1'b0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul_d) begin
              mul_a_q <= mag_a_d;
              mul_b_q <= mag_b_d;
              neg_q   <= is_signed_d & (rs_val[31] ^ rt_val[31]);
              acc_q   <= is_acc_d;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
              state_q <= S_WAIT;
            end else if (op == OP_MTHI) begin
              hi_q <= rs_val;
            end else if (op == OP_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            prod_q  <= mul_z;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_FIX: begin
          {hi_q, lo_q} <= wr_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with a behavioural unsigned multiplier on mul_z.
module tb_mdu_ctrl;
  localparam int unsigned MC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] mul_z;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  assign mul_z = {32'd0, mul_a} * {32'd0, mul_b};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue a multiply and check the busy/done timeline, operand stability, HI/LO hold and result.
  task automatic run_mul(input string tag, input logic [2:0] o, input logic [31:0] a, b,
                         input logic [31:0] ea, eb, input logic [63:0] exp);
    logic [63:0] old;
    old = {hi, lo};
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= int'(MC) + 2; k++) begin
      check({tag, "_busy"}, 64'(busy), 64'(k <= int'(MC) + 1));
      check({tag, "_done"}, 64'(done), 64'(k == int'(MC) + 2));
      check({tag, "_mul_a"}, 64'(mul_a), 64'(ea));
      check({tag, "_mul_b"}, 64'(mul_b), 64'(eb));
      if (k <= int'(MC) + 1) check({tag, "_hold"}, {hi, lo}, old);
      else                   check({tag, "_res"}, {hi, lo}, exp);
      if (k < int'(MC) + 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check({tag, "_done_clr"}, 64'(done), 64'd0);
  endtask

  task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] v);
    logic [63:0] exp;
    exp = (o == 3'b011) ? {v, lo} : {hi, v};
    start = 1'b1; op = o; rs_val = v;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_hilo"}, {hi, lo}, exp);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // A command that must change nothing: HI/LO held, never busy, never done.
  task automatic no_effect(input string tag, input logic [2:0] o);
    logic [63:0] old;
    old = {hi, lo};
    start = 1'b1; op = o; rs_val = 32'h0000_0001; rt_val = 32'h0000_0001;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < int'(MC) + 3; k++) begin
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, "_hilo"}, {hi, lo}, old);
  endtask

  initial begin
    int dones;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_mul",  {mul_a, mul_b}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_mul("multu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_mul("mult_neg", 3'b001, 32'hFFFF_FFFD, 32'h0000_0007,
            32'h0000_0003, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mul("mult_min", 3'b001, 32'h8000_0000, 32'h8000_0000,
            32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_mul("mult_two_neg", 3'b001, 32'hFFFF_FFF9, 32'hFFFF_FFFA,
            32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A);
    run_mul("mult_zero", 3'b001, 32'h0000_0000, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h0000_0001, 64'h0);

    // Second start one cycle later must be dropped.
    start = 1'b1; op = 3'b010; rs_val = 32'd2; rt_val = 32'd3;
    @(posedge clk); #1 rs_val = 32'd5; rt_val = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    dones = 0;
    for (int k = 0; k < int'(MC) + 6; k++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("busy_ignore_dones", 64'(dones), 64'd1);
    check("busy_ignore_res", {hi, lo}, 64'd6);

    move_to("mthi", 3'b011, 32'h1234_5678);
    check("mthi_done_next", 64'(done), 64'd0);
    move_to("mtlo", 3'b100, 32'hCAFE_F00D);
    no_effect("nop", 3'b000);
    no_effect("rsvd", 3'b111);

    // Reset during WAIT aborts the multiply.
    start = 1'b1; op = 3'b010; rs_val = 32'd7; rt_val = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_mul", {mul_a, mul_b}, 64'd0);
    #2 rst = 1'b0;
    dones = 0;
    for (int k = 0; k < int'(MC) + 4; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);

    // First edge after reset release must accept a start.
    rst = 1'b1;
    start = 1'b1; op = 3'b010; rs_val = 32'd3; rt_val = 32'd4;
    #3 rst = 1'b0;
    run_mul("post_rst", 3'b010, 32'd3, 32'd4, 32'd3, 32'd4, 64'd12);

    move_to("madd_mtlo", 3'b100, 32'hFFFF_FFFF);
    move_to("madd_mthi", 3'b011, 32'h0000_0000);
`ifdef MDU_MADD_EN
    run_mul("maddu", 3'b110, 32'd1, 32'd1, 32'd1, 32'd1, 64'h0000_0001_0000_0000);
`else
    no_effect("maddu_off", 3'b110);
    check("maddu_off_val", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
